// File: rtl/ahb_uart_tx_arbiter.sv
// ahb_uart_tx_arbiter
// Two byte requesters share one AHB master that feeds a memory-mapped UART.
// After reset the UART control register is written once. After that each
// accepted byte waits in a hold register while the master polls STATUS until
// the tx FIFO has room, then writes the byte to TXDATA. A request is granted
// only in IDLE. When both requesters are valid, a round-robin pointer picks one.
// Ports:
//   HCLK, HRESET               clock, async active-high reset
//   HADDR/HTRANS/HWRITE/HSIZE  AHB address phase (NONSEQ or IDLE only)
//   HWDATA, HRDATA, HREADY     AHB data phase
//   reqN_valid/data/ready      byte requesters 0 and 1 (ready = accepted)
//   busy                       FSM is not in IDLE
//   tx_stall                   sticky flag: tx FIFO seen full POLL_MAX polls in a row
module ahb_uart_tx_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h5100_0000,
  parameter logic [7:0]  CTRL_INIT = 8'h0C,
  parameter int unsigned POLL_MAX  = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic        busy,
  output logic        tx_stall
);
  localparam int unsigned   CW      = $clog2(POLL_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(POLL_MAX);
  localparam logic [1:0]    NONSEQ  = 2'b10;

  typedef enum logic [2:0] {
    INIT_A, INIT_D, IDLE, STAT_A, STAT_D, CHECK, WR_A, WR_D
  } state_e;

  state_e        state_q, state_d;
  logic          rr_q, rr_d;         // 0: requester 0 wins a tie
  logic          served_q, served_d; // requester whose byte is in flight
  logic          full_q, full_d;     // STATUS bit0 from the last poll
  logic          stall_q, stall_d;
  logic [7:0]    hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   haddr_q, hwdata_q;  // last driven values, held outside phases
  logic          grant0, grant1;
  logic          unused_hrdata;

  assign unused_hrdata = ^HRDATA[31:1];

  // state_q is INIT_A while reset is held, so no grant can occur then.
  assign grant0 = (state_q == IDLE) && req0_valid && (!req1_valid || !rr_q);
  assign grant1 = (state_q == IDLE) && req1_valid && (!req0_valid ||  rr_q);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= INIT_A;
      rr_q     <= 1'b0;
      served_q <= 1'b0;
      full_q   <= 1'b0;
      stall_q  <= 1'b0;
      hold_q   <= '0;
      cnt_q    <= '0;
      haddr_q  <= '0;
      hwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      served_q <= served_d;
      full_q   <= full_d;
      stall_q  <= stall_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      haddr_q  <= HADDR;
      hwdata_q <= HWDATA;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    served_d = served_q;
    full_d   = full_q;
    stall_d  = stall_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    case (state_q)
      INIT_A: if (HREADY) state_d = INIT_D;
      INIT_D: if (HREADY) state_d = IDLE;
      IDLE: begin
        if (grant0 || grant1) begin
          hold_d   = grant1 ? req1_data : req0_data;
          served_d = grant1;
          state_d  = STAT_A;
        end
      end
      STAT_A: if (HREADY) state_d = STAT_D;
      STAT_D: begin
        if (HREADY) begin
          full_d  = HRDATA[0];
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!full_q) begin
          cnt_d   = '0;
          state_d = WR_A;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_MAX) stall_d = 1'b1;
          state_d = STAT_A;
        end
      end
      WR_A: if (HREADY) state_d = WR_D;
      WR_D: begin
        if (HREADY) begin
          rr_d    = !served_q;
          stall_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = INIT_A;
    endcase
  end

  // Bus outputs are decoded from the state. Reset gating keeps the INIT_A
  // address phase off the bus while HRESET is high.
  always_comb begin
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HSIZE  = 3'b010;
    HADDR  = haddr_q;
    HWDATA = hwdata_q;
    if (!HRESET) begin
      case (state_q)
        INIT_A: begin
          HTRANS = NONSEQ;
          HWRITE = 1'b1;
          HADDR  = BASE_ADDR + 32'hC;
        end
        INIT_D: HWDATA = {24'b0, CTRL_INIT};
        STAT_A: begin
          HTRANS = NONSEQ;
          HADDR  = BASE_ADDR + 32'h8;
        end
        WR_A: begin
          HTRANS = NONSEQ;
          HWRITE = 1'b1;
          HADDR  = BASE_ADDR + 32'h4;
        end
        WR_D:    HWDATA = {24'b0, hold_q};
        default: ;
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = !HRESET && (state_q != IDLE);
  assign tx_stall   = stall_q;

endmodule

// File: tb/tb_ahb_uart_tx_arbiter.sv
module tb_ahb_uart_tx_arbiter;
  localparam logic [31:0] BASE   = 32'h5100_0000;
  localparam logic [31:0] A_TX   = BASE + 32'h4;
  localparam logic [31:0] A_STAT = BASE + 32'h8;
  localparam logic [31:0] A_CTRL = BASE + 32'hC;
  localparam int          PMAX   = 16;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY;
  logic [2:0]  HSIZE;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0]  req0_data, req1_data;
  logic        busy, tx_stall;

  always #5 HCLK = ~HCLK;

  ahb_uart_tx_arbiter dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .busy(busy), .tx_stall(tx_stall)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: what the bus must do next, the bytes owed to
  // TXDATA in acceptance order, the tie-break owner and the full-poll run.
  logic [7:0]  bq[$];
  logic [31:0] exp_addr;   // next address phase expected, 0 = wait for a grant
  int          dph;        // open data phase: 0 none, 1 status, 2 ctrl, 3 txdata
  int          rr_m, fulls, stall_left, n_tx, n_grant, stuck;
  logic        srv, ret_full, acc0, acc1, rst_done, rst_rel, abort;
  logic [31:0] hr_next;

  task automatic chk_rst();
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_hsize", 32'(HSIZE), 32'd2);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(tx_stall), 32'd0);
  endtask

  task automatic model_reset();
    bq.delete();
    exp_addr = A_CTRL;
    dph = 0; rr_m = 0; fulls = 0; stuck = 0;
  endtask

  task automatic monitor();
    logic       idle_m;
    logic [1:0] eg;
    logic [31:0] tmp;
    idle_m = (exp_addr == 32'd0) && (dph == 0);

    // Reset in the middle of a TXDATA data phase: the held byte is lost.
    if (!rst_done && n_tx >= 8 && dph == 3) begin
      HRESET = 1'b1;
      #1;
      chk_rst();
      model_reset();
      rst_done = 1'b1; rst_rel = 1'b1; acc0 = 1'b0; acc1 = 1'b0;
      return;
    end

    chk("hsize", 32'(HSIZE), 32'd2);
    if (dph != 0) begin
      chk("htrans_dphase", 32'(HTRANS), 32'd0);
      if (dph == 2) chk("hwdata_ctrl", HWDATA, 32'h0000_000C);
      if (dph == 3) chk("hwdata_tx", HWDATA, {24'b0, bq[0]});
      if (HREADY) begin
        case (dph)
          1: begin
            if (ret_full) begin fulls++; exp_addr = A_STAT; end
            else exp_addr = A_TX;
          end
          2: exp_addr = 32'd0;
          default: begin
            void'(bq.pop_front());
            rr_m = srv ? 0 : 1;
            fulls = 0; n_tx++;
            exp_addr = 32'd0;
          end
        endcase
        dph = 0;
      end
    end else if (HTRANS == 2'b10) begin
      stuck = 0;
      chk("haddr", HADDR, exp_addr);
      chk("hwrite", 32'(HWRITE), 32'(exp_addr != A_STAT));
      chk("stall_at_addr", 32'(tx_stall), 32'(fulls >= PMAX));
      if (HREADY) begin
        if (HADDR == A_STAT) begin
          dph = 1;
          ret_full = (stall_left > 0);
          if (ret_full) stall_left--;
          tmp = $urandom; tmp[0] = ret_full; hr_next = tmp;
        end else if (HADDR == A_CTRL) dph = 2;
        else dph = 3;
      end
    end else begin
      chk("htrans_idle", 32'(HTRANS), 32'd0);
      chk("hwrite_idle", 32'(HWRITE), 32'd0);
      if (exp_addr != 32'd0) begin
        stuck++;
        if (stuck > 4) begin
          chk("addr_timeout", 32'd0, 32'd1);
          abort = 1'b1;
        end
      end
    end

    eg = 2'b00;
    if (idle_m) begin
      if (req0_valid && req1_valid) eg = (rr_m != 0) ? 2'b10 : 2'b01;
      else eg = {req1_valid, req0_valid};
    end
    chk("ready", 32'({req1_ready, req0_ready}), 32'(eg));
    chk("busy", 32'(busy), 32'(!idle_m));
    if (idle_m) chk("stall_idle", 32'(tx_stall), 32'd0);
    acc0 = req0_ready; acc1 = req1_ready;
    if (eg != 2'b00) begin
      bq.push_back(eg[1] ? req1_data : req0_data);
      srv = eg[1];
      exp_addr = A_STAT;
      stall_left = (n_grant % 5 == 2) ? PMAX + (n_grant % 2) : $urandom_range(0, 2);
      n_grant++;
    end
  endtask

  task automatic drive();
    if (rst_rel) begin HRESET = 1'b0; rst_rel = 1'b0; end
    HREADY = ($urandom_range(0, 3) != 0);
    HRDATA = hr_next;
    if (acc0) req0_valid = 1'b0;
    if (acc1) req1_valid = 1'b0;
    if (!req0_valid && $urandom_range(0, 2) == 0) begin
      req0_valid = 1'b1; req0_data = 8'($urandom);
    end
    if (!req1_valid && $urandom_range(0, 2) == 0) begin
      req1_valid = 1'b1; req1_data = 8'($urandom);
    end
  endtask

  initial begin
    HRESET = 1'b1; HREADY = 1'b1; HRDATA = '0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    n_tx = 0; n_grant = 0; stall_left = 0; srv = 1'b0; ret_full = 1'b0;
    acc0 = 1'b0; acc1 = 1'b0; rst_done = 1'b0; rst_rel = 1'b0; abort = 1'b0;
    hr_next = '0;
    model_reset();
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk_rst();
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    // Simultaneous requests straight after reset: requester 0 wins first.
    req0_valid = 1'b1; req0_data = 8'hA7;
    req1_valid = 1'b1; req1_data = 8'h34;
    for (int cyc = 0; cyc < 4000 && !abort; cyc++) begin
      @(negedge HCLK);
      monitor();
      @(posedge HCLK); #1;
      drive();
    end
    chk("tx_count_min", 32'(n_tx >= 40), 32'd1);
    chk("reset_injected", 32'(rst_done), 32'd1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_uart_tx_arbiter.md
AHB_UART_TX_ARBITER -- requirements
Module: ahb_uart_tx_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- BASE_ADDR, 32'h5100_0000, UART register base address.
- CTRL_INIT, 8'h0C, value written to CONTRL after reset.
- POLL_MAX, 16, consecutive tx-full polls before stall is flagged.

REQ-002 The block SHALL have these ports, one clock and an asynchronous active-high reset:
- HCLK  in  1  bus clock; all state changes on the rising edge.
- HRESET  in  1  asynchronous active-high reset.
- HADDR  out  32  master address.
- HTRANS  out  2  transfer type; only IDLE (00) and NONSEQ (10) are used.
- HWRITE  out  1  write transfer.
- HSIZE  out  3  always WORD (010).
- HWDATA  out  32  write data, driven in the data phase.
- HRDATA  in  32  read data.
- HREADY  in  1  bus ready.
- req0_valid / req1_valid  in  1  requester has a byte.
- req0_data / req1_data  in  8  requester byte.
- req0_ready / req1_ready  out  1  byte accepted this cycle.
- busy  out  1  any state other than IDLE.
- tx_stall  out  1  sticky: the UART tx FIFO has been full for POLL_MAX polls.

Function
REQ-003 Register offsets SHALL be TXDATA = BASE_ADDR+4, STATUS = BASE_ADDR+8, CONTRL = BASE_ADDR+0xC; STATUS bit0 = tx FIFO full.

REQ-004 The FSM states SHALL be INIT_A, INIT_D, IDLE, STAT_A, STAT_D, CHECK, WR_A, WR_D.

REQ-005 Every transfer SHALL be a single NONSEQ address phase followed by HTRANS=IDLE during its data phase. Transfers are never pipelined back-to-back.

REQ-006 An address phase SHALL hold HADDR/HWRITE/HTRANS until sampled with HREADY=1. A data phase SHALL hold HWDATA and extend while HREADY=0.

REQ-007 Reset release SHALL enter INIT_A, which issues a write to CONTRL. INIT_D drives HWDATA={24'b0,CTRL_INIT}, then the FSM goes to IDLE.

REQ-008 In IDLE, the grant SHALL be decided as follows:
- If exactly one reqN_valid=1, that requester is granted.
- If both are valid, the requester indicated by the round-robin pointer rr is granted.
- reqN_ready pulses high for exactly that one cycle.
- reqN_data is latched into an 8-bit hold register.
- The FSM goes to STAT_A.

REQ-009 reqN_ready SHALL never be high outside IDLE, and never high for both requesters in the same cycle.

REQ-010 STAT_A SHALL issue a read of STATUS. STAT_D captures HRDATA[0] on the cycle HREADY=1, then the FSM goes to CHECK.

REQ-011 In CHECK:
- If the captured full bit = 0, go to WR_A and clear the poll counter.
- Otherwise increment the poll counter (saturating at POLL_MAX), set tx_stall when the counter reaches POLL_MAX, and return to STAT_A.

REQ-012 WR_A SHALL issue a write to TXDATA. WR_D drives HWDATA={24'b0,hold}.

REQ-013 On WR_D completion (HREADY=1), the block SHALL:
- set rr to the requester not just served;
- clear tx_stall;
- go to IDLE.

REQ-014 Minimum latency from acceptance in IDLE to the TXDATA data-phase completion SHALL be 6 cycles with HREADY held at 1. The next grant is possible on the following cycle.

REQ-015 A byte SHALL be neither accepted nor dropped while the FSM is not in IDLE. Requesters hold valid and data until ready.

REQ-016 The outputs outside transfer phases SHALL be: HTRANS=IDLE, HWRITE=0, HSIZE=010. HADDR and HWDATA retain their last values.

Reset
REQ-017 HRESET=1 SHALL asynchronously force every output and register to its reset value:
- HTRANS=00, HADDR=0, HWRITE=0, HSIZE=010, HWDATA=0;
- req0_ready=0, req1_ready=0, busy=0, tx_stall=0;
- rr=0 (requester 0 favoured), poll counter=0, hold=0;
- state=INIT_A, held low while HRESET=1.

REQ-018 Reset asserted mid-transfer SHALL abandon that transfer immediately and discard any held byte. The CONTRL initialisation repeats after release.

Verification
REQ-019 Reset release with HREADY=1 -> the first NONSEQ write has HADDR=0x5100_000C, and the next cycle has HWDATA=0x0000_000C; busy=0 afterwards.

REQ-020 req0_valid=1 with data 0x65, STATUS read returns 0x2 -> STATUS read at 0x5100_0008, then a write at 0x5100_0004 with HWDATA=0x0000_0065; req0_ready high exactly one cycle.

REQ-021 Both requesters valid (0xA7 on req0, 0x34 on req1) after reset -> TXDATA writes occur in order 0xA7, 0x34, and rr=0 afterwards.

REQ-022 STATUS returns 0x1 for 16 consecutive reads, then 0x2 -> tx_stall rises after the 16th poll, the TXDATA write follows, and tx_stall clears on its completion.

REQ-023 HREADY held low 3 cycles during the STAT_D and WR_D data phases -> HWDATA and the state are held, and the write completes with the correct byte.

REQ-024 HRESET asserted during WR_D -> all outputs return to their reset values in the same cycle, no further TXDATA write occurs for that byte, and the CONTRL write repeats after release.
